// File: rtl/fp_stream_accumulator.sv
`timescale 1ns/1ps
// Single-precision stream accumulator: align/add/normalize FSM, one element per 4 cycles; FP_ACC_RNE_EN selects RNE rounding (default truncate).
// Latency: last element accepted at cycle t -> out_vld high at t+4.
// Backpressure: in_rdy only in IDLE; out_vld/FP_sum/sum_cnt held in DONE until out_rdy.
module fp_stream_accumulator #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [31:0]      FP_in,
   input  logic             in_last,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [31:0]      FP_sum,
   output logic [CNT_W-1:0] sum_cnt
);
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp_t;

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t           state_q, state_d;
   fp_t              acc_q, b_q, big, norm_res;
   logic             last_q, accept;
   logic [CNT_W-1:0] cnt_q;
   logic [26:0]      big_sig_q, sm_sig_q;
   logic [7:0]       exp_q;
   logic             sign_q, sub_q, spec_hit_q;
   logic [31:0]      spec_val_q;
   logic [27:0]      sum_q;

   function automatic logic [4:0] lead_one(input logic [27:0] v);
      lead_one = 5'd0;
      for (int i = 0; i < 28; i++)
         if (v[i]) lead_one = i[4:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_rdy = ~rst;
            if (in_vld) state_d = S_ALIGN;
         end
         S_ALIGN: state_d = S_ADD;
         S_ADD:   state_d = S_NORM;
         S_NORM:  state_d = last_q ? S_DONE : S_IDLE;
         S_DONE: begin
            out_vld = 1'b1;
            if (out_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept  = in_vld & in_rdy;
   assign FP_sum  = out_vld ? acc_q : 32'd0;
   assign sum_cnt = out_vld ? cnt_q : '0;

   // Align: order operands by magnitude, shift the smaller one keeping guard/round/sticky.
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, swap, spec_hit;
   logic [31:0] spec_val;
   logic [7:0]  sm_exp, shamt;
   logic [22:0] sm_man;
   logic [26:0] sm_full, sm_shift, sm_lost, sm_sig;

   always_comb begin
      a_zero   = (acc_q.exp == 8'h00);
      b_zero   = (b_q.exp == 8'h00);
      a_inf    = (acc_q.exp == 8'hFF);
      b_inf    = (b_q.exp == 8'hFF);
      a_nan    = a_inf & (|acc_q.man);
      swap     = (b_q[30:0] > acc_q[30:0]);
      big      = swap ? b_q : acc_q;
      sm_exp   = swap ? acc_q.exp : b_q.exp;
      sm_man   = swap ? acc_q.man : b_q.man;
      shamt    = big.exp - sm_exp;
      sm_full  = {1'b1, sm_man, 3'b000};
      sm_shift = sm_full >> shamt;
      sm_lost  = sm_full & ((27'd1 << shamt) - 27'd1);
      sm_sig   = (shamt >= 8'd27) ? 27'd0 : {sm_shift[26:1], sm_shift[0] | (|sm_lost)};

      spec_hit = 1'b1;
      spec_val = acc_q;
      if (a_nan)                                   spec_val = acc_q;
      else if (a_inf && b_inf && (acc_q.sign != b_q.sign)) spec_val = 32'h7FC0_0000;
      else if (a_inf)                              spec_val = {acc_q.sign, 8'hFF, 23'd0};
      else if (b_inf)                              spec_val = {b_q.sign, 8'hFF, 23'd0};
      else if (b_zero)                             spec_val = acc_q;
      else if (a_zero)                             spec_val = b_q;
      else                                         spec_hit = 1'b0;
   end

   // Normalize: bit 26 of the aligned significand is the hidden one.
   logic [4:0]        lead, lz;
   logic [26:0]       norm;
   logic signed [9:0] exp_n, exp_r;
   logic              round_up;
   logic [24:0]       rnd;
   logic [22:0]       man_r;

   always_comb begin
      lead = lead_one(sum_q);
      lz   = 5'd26 - lead;
      if (sum_q[27]) begin
         norm  = {sum_q[27:2], sum_q[1] | sum_q[0]};
         exp_n = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         norm  = sum_q[26:0] << lz;
         exp_n = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
      end
   end

`ifdef FP_ACC_RNE_EN
   assign round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
`else
   logic grs_unused;
   assign round_up   = 1'b0;
   assign grs_unused = |norm[2:0];
`endif

   always_comb begin
      rnd   = {1'b0, norm[26:3]} + {24'd0, round_up};
      exp_r = rnd[24] ? exp_n + 10'sd1 : exp_n;
      man_r = rnd[24] ? rnd[23:1] : rnd[22:0];
      if (spec_hit_q)                           norm_res = spec_val_q;
      else if (sum_q == 28'd0 || exp_r < 10'sd1) norm_res = 32'd0;
      else if (exp_r >= 10'sd255)                norm_res = {sign_q, 8'hFF, 23'd0};
      else                                       norm_res = {sign_q, exp_r[7:0], man_r};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         b_q        <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         big_sig_q  <= '0;
         sm_sig_q   <= '0;
         exp_q      <= '0;
         sign_q     <= 1'b0;
         sub_q      <= 1'b0;
         spec_hit_q <= 1'b0;
         spec_val_q <= '0;
         sum_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               b_q    <= FP_in;
               last_q <= in_last;
               if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            S_ALIGN: begin
               big_sig_q  <= {1'b1, big.man, 3'b000};
               sm_sig_q   <= sm_sig;
               exp_q      <= big.exp;
               sign_q     <= big.sign;
               sub_q      <= acc_q.sign ^ b_q.sign;
               spec_hit_q <= spec_hit;
               spec_val_q <= spec_val;
            end
            S_ADD: sum_q <= sub_q ? ({1'b0, big_sig_q} - {1'b0, sm_sig_q})
                                  : ({1'b0, big_sig_q} + {1'b0, sm_sig_q});
            S_NORM: acc_q <= norm_res;
            S_DONE: if (out_rdy) begin
               acc_q <= '0;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule
